alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator side of the team's combinational ALU interface (alu_sel/alu_a/alu_b in, alu_res/alu_ovf out). Accepts one command at a time over a valid/ready handshake and drives the ALU operands. Builds multi-bit shifts from the ALU's 1-bit shift ops. Returns a registered result over a second valid/ready handshake. Sits between the command source (switch/bus logic) and the ALU.

Parameters:
DATA_W, 32, operand/result width; must equal the ALU width
SHAMT_W, 5, shift-amount width; taken from cmd_b[SHAMT_W-1:0]
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept; equals (state==IDLE)
cmd_op  in  4  opcode in the ALU sel encoding: 1 add, 2 sub, 3 xor, 4 and, 5 or, 6 sll, 7 srl, 8 sra, 9 slt
cmd_a  in  DATA_W  operand a
cmd_b  in  DATA_W  operand b; shift amount for ops 6-8
rsp_valid  out  1  response held
rsp_ready  in  1  consumer takes response
rsp_res  out  DATA_W  result
rsp_ovf  out  1  signed overflow (add/sub only)
rsp_err  out  1  illegal opcode
alu_sel  out  4  to ALU
alu_a  out  DATA_W  to ALU
alu_b  out  DATA_W  to ALU
alu_res  in  DATA_W  from ALU, combinational
alu_ovf  in  1  from ALU, combinational
op_count  out  CNT_W  completed response handshakes, wraps

Behaviour:
- Reset values: state IDLE; rsp_valid, rsp_res, rsp_ovf, rsp_err, op_count = 0; internal op/a/b/shift/count registers = 0.
- ALU contract: ops 1-5 and 9 are functions of alu_a and alu_b. Ops 6/7/8 return alu_a shifted by exactly 1 bit (logical left, logical right, arithmetic right).
- When the state is not EXEC or SHIFT, alu_sel = 0 and alu_a = alu_b = 0.
- States: IDLE, EXEC, SHIFT, RESP.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) latches op, a and b, then transitions as follows:
  - op in {1-5, 9} -> EXEC.
  - op in {6, 7, 8} with shamt != 0 -> SHIFT. shift_reg<=a, cnt<=shamt.
  - op in {6, 7, 8} with shamt == 0 -> RESP. res=a, ovf=0, err=0.
  - op in {0, 10-15} -> RESP. res=0, ovf=0, err=1.
- EXEC, exactly one cycle: drive alu_sel=op, alu_a=a_q, alu_b=b_q. At the next edge, capture rsp_res<=alu_res, rsp_ovf<=(op is 1 or 2) & alu_ovf, rsp_err<=0, then go to RESP.
- Latency for non-shift ops: command accepted at edge k -> rsp_valid=1 after edge k+1.
- SHIFT: drive alu_sel=op, alu_a=shift_reg, alu_b=0. Each edge, shift_reg<=alu_res and cnt<=cnt-1.
  - When cnt==1, capture alu_res into rsp_res, set ovf=0 and err=0, and go to RESP.
  - A shift by n occupies exactly n SHIFT cycles; the response is visible after edge k+n.
- RESP: rsp_valid=1; rsp_res, rsp_ovf and rsp_err are stable. cmd_ready=0.
  - On rsp_ready=1: op_count increments (wrapping 2^CNT_W-1 -> 0), rsp_valid drops, and the state returns to IDLE at that edge.
  - rsp_ready=1 outside RESP is ignored.
- There is no command overlap. A new command can be accepted no earlier than the cycle after the response handshake.
- Inputs cmd_a, cmd_b and cmd_op are sampled only at the command handshake. Later changes have no effect on the command in flight.
- rsp_res/ovf/err keep their last values after the handshake until the next capture.
- Reset asserted mid-operation: immediate abort to reset values, no response emitted, op_count cleared.
- Arithmetic width: all datapath DATA_W bits, no extension. The slt result comes from the ALU unmodified.

Test Plan:
- Add op=1, a=0x7FFFFFFF, b=0x00000001, rsp_ready=1 -> rsp_valid one cycle after accept; res=0x80000000, ovf=1, err=0; op_count=1.
- Sub op=2, a=5, b=7, then slt op=9, a=5, b=7 back-to-back -> res=0xFFFFFFFE with ovf=0, then res=0x00000001; cmd_ready low from accept through the response handshake.
- Sra op=8, a=0x80000010, b=4 -> exactly 4 SHIFT cycles with alu_sel=8; res=0xF8000001, ovf=0. Sll op=6, a=1, b=31 -> res=0x80000000 after 31 cycles.
- Shift with b=0x20 (shamt=0), a=0x1234 -> RESP next cycle with res=0x00001234. Illegal op=0xF -> res=0, err=1.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid and result stable, cmd_ready=0, cmd_valid ignored; op_count increments once on release.
- Assert rst during the 2nd cycle of a 10-cycle shift -> all outputs zero, IDLE with cmd_ready=1 after release, no rsp_valid. Run 2^16 ops with CNT_W=16 -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between a command source and the ALU sequencer.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_res;
  logic              rsp_ovf;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_res, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_res, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Single-command initiator for the combinational ALU; multi-bit shifts are
// built by iterating the ALU's 1-bit shift ops, one bit per cycle.
module alu_cmd_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_sequencer_if.slave     bus,
  output logic [3:0]             alu_sel,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  input  logic [DATA_W-1:0]      alu_res,
  input  logic                   alu_ovf,
  output logic [CNT_W-1:0]       op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_shift;
  logic [SHAMT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_res;
  logic              r_ovf;
  logic              r_err;
  logic [CNT_W-1:0]  r_op_count;

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_cmd_fire;

  assign w_shamt    = bus.cmd_b[SHAMT_W-1:0];
  assign w_cmd_fire = bus.cmd_valid && (r_state == IDLE);

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_res   = r_res;
  assign bus.rsp_ovf   = r_ovf;
  assign bus.rsp_err   = r_err;
  assign op_count      = r_op_count;

  always_comb begin
    alu_sel = 4'd0;
    alu_a   = '0;
    alu_b   = '0;
    if (r_state == EXEC) begin
      alu_sel = r_op;
      alu_a   = r_a;
      alu_b   = r_b;
    end else if (r_state == SHIFT) begin
      alu_sel = r_op;
      alu_a   = r_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= 4'd0;
      r_a        <= '0;
      r_b        <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_res      <= '0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_op <= bus.cmd_op;
            r_a  <= bus.cmd_a;
            r_b  <= bus.cmd_b;
            case (bus.cmd_op)
              4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9: r_state <= EXEC;
              4'd6, 4'd7, 4'd8: begin
                if (w_shamt != '0) begin
                  r_shift <= bus.cmd_a;
                  r_cnt   <= w_shamt;
                  r_state <= SHIFT;
                end else begin
                  // Zero-length shift: the operand is already the answer.
                  r_res   <= bus.cmd_a;
                  r_ovf   <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= RESP;
                end
              end
              default: begin
                r_res   <= '0;
                r_ovf   <= 1'b0;
                r_err   <= 1'b1;
                r_state <= RESP;
              end
            endcase
          end
        end
        EXEC: begin
          r_res   <= alu_res;
          r_ovf   <= ((r_op == 4'd1) || (r_op == 4'd2)) && alu_ovf;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        SHIFT: begin
          r_shift <= alu_res;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_res   <= alu_res;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= RESP;
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            r_op_count <= r_op_count + 1'b1;
            r_state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached; a
// second small-counter instance exercises op_count wrap.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  alu_cmd_sequencer_if #(.DATA_W(32)) u_if ();
  alu_cmd_sequencer_if #(.DATA_W(32)) u_if2 ();

  logic [3:0]  alu_sel, alu_sel2;
  logic [31:0] alu_a, alu_b, alu_res, alu_a2, alu_b2, alu_res2;
  logic        alu_ovf, alu_ovf2;
  logic [15:0] op_count;
  logic [3:0]  op_count2;

  function automatic logic [32:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        o;
    r = 32'd0;
    o = 1'b0;
    case (s)
      4'd1: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd2: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd3: r = a ^ b;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      4'd8: r = {a[31], a[31:1]};
      4'd9: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {o, r};
  endfunction

  always_comb {alu_ovf, alu_res}   = alu_f(alu_sel, alu_a, alu_b);
  always_comb {alu_ovf2, alu_res2} = alu_f(alu_sel2, alu_a2, alu_b2);

  alu_cmd_sequencer #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(u_if.slave),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_ovf(alu_ovf), .op_count(op_count)
  );

  alu_cmd_sequencer #(.DATA_W(32), .SHAMT_W(5), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .bus(u_if2.slave),
    .alu_sel(alu_sel2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_res(alu_res2), .alu_ovf(alu_ovf2), .op_count(op_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_a     = a;
    u_if.cmd_b     = b;
    step();
    u_if.cmd_valid = 1'b0;
    $display("cmd op=%0d a=%h b=%h accepted at t=%0t", op, a, b, $time);
  endtask

  task automatic take();
    u_if.rsp_ready = 1'b1;
    step();
    u_if.rsp_ready = 1'b0;
    $display("rsp res=%h ovf=%0b err=%0b count=%0d", u_if.rsp_res, u_if.rsp_ovf, u_if.rsp_err, op_count);
  endtask

  initial begin
    u_if.cmd_valid = 1'b0; u_if.cmd_op = 4'd0; u_if.cmd_a = 32'd0; u_if.cmd_b = 32'd0; u_if.rsp_ready = 1'b0;
    u_if2.cmd_valid = 1'b0; u_if2.cmd_op = 4'd0; u_if2.cmd_a = 32'd0; u_if2.cmd_b = 32'd0; u_if2.rsp_ready = 1'b0;
    step(); step();
    chk("rst_cmd_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    chk("rst_rsp_res", u_if.rsp_res, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    rst = 1'b0;
    step();

    // Add with overflow; operand change after accept must not matter
    send(4'd1, 32'h7FFF_FFFF, 32'h0000_0001);
    u_if.cmd_a = 32'd0;
    chk("add_exec_ready", {31'd0, u_if.cmd_ready}, 32'd0);
    chk("add_exec_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    chk("add_alu_sel", {28'd0, alu_sel}, 32'd1);
    chk("add_alu_a", alu_a, 32'h7FFF_FFFF);
    step();
    chk("add_valid", {31'd0, u_if.rsp_valid}, 32'd1);
    chk("add_res", u_if.rsp_res, 32'h8000_0000);
    chk("add_ovf", {31'd0, u_if.rsp_ovf}, 32'd1);
    chk("add_err", {31'd0, u_if.rsp_err}, 32'd0);
    take();
    chk("add_count", {16'd0, op_count}, 32'd1);
    chk("add_post_valid", {31'd0, u_if.rsp_valid}, 32'd0);

    // rsp_ready while idle is ignored
    u_if.rsp_ready = 1'b1;
    step();
    u_if.rsp_ready = 1'b0;
    chk("idle_ready_ignored", {16'd0, op_count}, 32'd1);

    send(4'd2, 32'd5, 32'd7);
    step();
    chk("sub_res", u_if.rsp_res, 32'hFFFF_FFFE);
    chk("sub_ovf", {31'd0, u_if.rsp_ovf}, 32'd0);
    chk("sub_resp_ready", {31'd0, u_if.cmd_ready}, 32'd0);
    take();
    send(4'd9, 32'd5, 32'd7);
    step();
    chk("slt_res", u_if.rsp_res, 32'd1);
    take();
    chk("slt_count", {16'd0, op_count}, 32'd3);

    // Arithmetic right shift by 4: exactly four SHIFT cycles
    send(4'd8, 32'h8000_0010, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sra_sel_%0d", i), {28'd0, alu_sel}, 32'd8);
      chk($sformatf("sra_busy_%0d", i), {31'd0, u_if.rsp_valid}, 32'd0);
      step();
    end
    chk("sra_valid", {31'd0, u_if.rsp_valid}, 32'd1);
    chk("sra_res", u_if.rsp_res, 32'hF800_0001);
    chk("sra_ovf", {31'd0, u_if.rsp_ovf}, 32'd0);
    take();

    send(4'd6, 32'd1, 32'd31);
    for (int i = 0; i < 30; i++) step();
    chk("sll_busy_30", {31'd0, u_if.rsp_valid}, 32'd0);
    step();
    chk("sll_valid_31", {31'd0, u_if.rsp_valid}, 32'd1);
    chk("sll_res", u_if.rsp_res, 32'h8000_0000);
    take();

    // shamt field is zero even though b is nonzero
    send(4'd7, 32'h0000_1234, 32'h0000_0020);
    chk("shamt0_valid", {31'd0, u_if.rsp_valid}, 32'd1);
    chk("shamt0_res", u_if.rsp_res, 32'h0000_1234);
    chk("shamt0_err", {31'd0, u_if.rsp_err}, 32'd0);
    take();
    chk("shamt0_count", {16'd0, op_count}, 32'd6);

    // Illegal op with backpressure and a competing command offered
    send(4'hF, 32'd5, 32'd5);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = 4'd1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_valid_%0d", i), {31'd0, u_if.rsp_valid}, 32'd1);
      chk($sformatf("bp_res_%0d", i), u_if.rsp_res, 32'd0);
      chk($sformatf("bp_err_%0d", i), {31'd0, u_if.rsp_err}, 32'd1);
      chk($sformatf("bp_ready_%0d", i), {31'd0, u_if.cmd_ready}, 32'd0);
      chk($sformatf("bp_count_%0d", i), {16'd0, op_count}, 32'd6);
      step();
    end
    u_if.cmd_valid = 1'b0;
    take();
    chk("bp_count_rel", {16'd0, op_count}, 32'd7);
    chk("bp_err_held", {31'd0, u_if.rsp_err}, 32'd1);
    chk("bp_idle", {31'd0, u_if.cmd_ready}, 32'd1);

    // Reset in the second cycle of a 10-bit shift
    send(4'd6, 32'd3, 32'd10);
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    chk("rst_mid_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_mid_a", alu_a, 32'd0);
    chk("rst_mid_err", {31'd0, u_if.rsp_err}, 32'd0);
    chk("rst_mid_count", {16'd0, op_count}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("rst_mid_no_rsp", {31'd0, u_if.rsp_valid}, 32'd0);
    chk("rst_mid_idle", {31'd0, u_if.cmd_ready}, 32'd1);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      u_if2.cmd_valid = 1'b1;
      u_if2.cmd_op    = 4'hE;
      step();
      u_if2.cmd_valid = 1'b0;
      u_if2.rsp_ready = 1'b1;
      step();
      u_if2.rsp_ready = 1'b0;
      if (i == 14) chk("wrap_count_15", {28'd0, op_count2}, 32'd15);
    end
    chk("wrap_count_0", {28'd0, op_count2}, 32'd0);
    $display("wrap instance op_count=%0d after 16 ops", op_count2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
